sort_seq_ctrl: RTL and testbench

SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

---
 rtl/sort_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sort_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sort_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sort_seq_ctrl
//   Sequential bubble-sort engine. A job of NUM_VALS unsigned SIZE-bit
//   elements is captured in IDLE, sorted in place with one compare-swap per
//   clock in SORT, and presented in descending order (element 0 = maximum)
//   in DONE until the consumer takes it.
//
// Parameters
//   NUM_VALS  elements per job (2..32)
//   SIZE      element width in bits
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a job
//   in_ready   block can accept a job (IDLE only)
//   in_data    job, element k at [k*SIZE +: SIZE]
//   out_valid  out_data holds a sorted result (DONE only)
//   out_ready  consumer accepts out_data
//   out_data   internal array, element k at [k*SIZE +: SIZE]
//   busy       high while sorting
//
// Configuration
//   SORT_EARLY_EXIT_EN  when defined, a pass that performs no swap ends the
//                       sort at that pass's last compare. Undefined: the
//                       latency is always NUM_VALS*(NUM_VALS-1)/2 cycles.
// ---------------------------------------------------------------------------

// Single compare-swap cell: larger value goes to the lower index.
module sort_seq_cswap #(
   parameter int SIZE = 16
) (
   input  logic [SIZE-1:0] a,     // element j
   input  logic [SIZE-1:0] b,     // element j+1
   output logic [SIZE-1:0] hi,    // new element j
   output logic [SIZE-1:0] lo,    // new element j+1
   output logic            swap
);
   // Strict compare: equal elements stay where they are.
   assign swap = (a < b);
   assign hi   = swap ? b : a;
   assign lo   = swap ? a : b;
endmodule

module sort_seq_ctrl #(
   parameter int NUM_VALS = 5,
   parameter int SIZE     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_VALS*SIZE-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_VALS*SIZE-1:0] out_data,
   output logic                     busy
);

   // Wide enough to hold NUM_VALS itself (pass bound starts there).
   localparam int BW = $clog2(NUM_VALS + 1);

   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t                          state;
   logic [NUM_VALS-1:0][SIZE-1:0]   arr;
   logic [NUM_VALS-1:0][SIZE-1:0]   arr_nxt;
   logic [BW-1:0]                   b;       // current pass bound
   logic [BW-1:0]                   j;       // current compare index
   logic [SIZE-1:0]                 cur_a, cur_b, new_a, new_b;
   logic                            do_swap;
   logic                            last_cmp;
   logic                            fin;

`ifdef SORT_EARLY_EXIT_EN
   logic                            pass_swp;  // a swap happened earlier in this pass
`endif

   assign out_data = arr;

   // Select elements j and j+1 by decode rather than a variable index so the
   // index width never has to match the array depth.
   always_comb begin
      cur_a = '0;
      cur_b = '0;
      for (int i = 0; i < NUM_VALS; i++) begin
         if (j == BW'(i))           cur_a = arr[i];
         if (j + BW'(1) == BW'(i))  cur_b = arr[i];
      end
   end

   sort_seq_cswap #(.SIZE(SIZE)) u_cswap (
      .a    (cur_a),
      .b    (cur_b),
      .hi   (new_a),
      .lo   (new_b),
      .swap (do_swap)
   );

   always_comb begin
      arr_nxt = arr;
      for (int i = 0; i < NUM_VALS; i++) begin
         if (j == BW'(i))
            arr_nxt[i] = new_a;
         else if (j + BW'(1) == BW'(i))
            arr_nxt[i] = new_b;
      end
   end

   // Last compare of the pass: j has reached b-2.
   assign last_cmp = (j == b - BW'(2));

`ifdef SORT_EARLY_EXIT_EN
   // A clean pass means the array is already ordered.
   assign fin = last_cmp && ((b == BW'(2)) || !(pass_swp || do_swap));
`else
   assign fin = last_cmp && (b == BW'(2));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         arr       <= '0;
         b         <= '0;
         j         <= '0;
`ifdef SORT_EARLY_EXIT_EN
         pass_swp  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  arr      <= in_data;
                  b        <= BW'(NUM_VALS);
                  j        <= '0;
                  state    <= SORT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
`ifdef SORT_EARLY_EXIT_EN
                  pass_swp <= 1'b0;
`endif
               end
            end
            SORT: begin
               arr <= arr_nxt;
               if (fin) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else if (last_cmp) begin
                  b <= b - BW'(1);
                  j <= '0;
`ifdef SORT_EARLY_EXIT_EN
                  pass_swp <= 1'b0;
`endif
               end else begin
                  j <= j + BW'(1);
`ifdef SORT_EARLY_EXIT_EN
                  pass_swp <= pass_swp | do_swap;
`endif
               end
            end
            DONE: begin
               // Hold the result until taken; no accept on the same edge.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sort_seq_ctrl
//   Bench for sort_seq_ctrl (NUM_VALS=5, SIZE=16). A job-level model predicts
//   the sorted result and the cycle at which it appears; a per-cycle process
//   compares handshake outputs and, when known, out_data against it. Directed
//   jobs also check literal results and latencies.
// ---------------------------------------------------------------------------
module tb_sort_seq_ctrl;

   localparam int N    = 5;
   localparam int W    = 16;
   localparam int LMAX = N * (N - 1) / 2;
`ifdef SORT_EARLY_EXIT_EN
   localparam int EE = 1;
`else
   localparam int EE = 0;
`endif
   localparam int LAT_SORTED = EE ? 4 : 10;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [N*W-1:0] in_data = '0;
   logic           in_ready, out_valid, busy;
   logic [N*W-1:0] out_data;

   int tests = 0;
   int fails = 0;

   sort_seq_ctrl #(.NUM_VALS(N), .SIZE(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] pk(input int a0, input int a1, input int a2,
                                         input int a3, input int a4);
      logic [N*W-1:0] r;
      r[0*W +: W] = a0[W-1:0];
      r[1*W +: W] = a1[W-1:0];
      r[2*W +: W] = a2[W-1:0];
      r[3*W +: W] = a3[W-1:0];
      r[4*W +: W] = a4[W-1:0];
      return r;
   endfunction

   // Descending order by repeated maximum selection.
   function automatic logic [N*W-1:0] m_sort(input logic [N*W-1:0] d);
      logic [W-1:0]   v[N];
      logic [W-1:0]   t;
      logic [N*W-1:0] r;
      for (int k = 0; k < N; k++) v[k] = d[k*W +: W];
      for (int k = 0; k < N; k++)
         for (int m = k + 1; m < N; m++)
            if (v[m] > v[k]) begin t = v[k]; v[k] = v[m]; v[m] = t; end
      for (int k = 0; k < N; k++) r[k*W +: W] = v[k];
      return r;
   endfunction

   // Number of compares before the result is ready.
   function automatic int m_lat(input logic [N*W-1:0] d);
      logic [W-1:0] v[N];
      logic [W-1:0] t;
      int  cnt;
      bit  sw;
      if (EE == 0) return LMAX;
      for (int k = 0; k < N; k++) v[k] = d[k*W +: W];
      cnt = 0;
      for (int bb = N; bb >= 2; bb--) begin
         sw = 0;
         for (int jj = 0; jj <= bb - 2; jj++) begin
            cnt++;
            if (v[jj] < v[jj+1]) begin t = v[jj]; v[jj] = v[jj+1]; v[jj+1] = t; sw = 1; end
         end
         if (!sw) return cnt;
      end
      return cnt;
   endfunction

   // Job-level model: 0 = waiting for job, 1 = sorting, 2 = result offered.
   int             m_ph = 0;
   int             m_cnt = 0;
   logic           m_known = 1'b0;
   logic [N*W-1:0] m_data = '0;
   logic [N*W-1:0] m_res = '0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ph = 0; m_known = 1'b1; m_data = '0;
      end else begin
         case (m_ph)
            0: if (in_valid) begin
                  m_res = m_sort(in_data); m_cnt = m_lat(in_data);
                  m_ph = 1; m_known = 1'b0;
               end
            1: begin
                  m_cnt--;
                  if (m_cnt == 0) begin m_ph = 2; m_known = 1'b1; m_data = m_res; end
               end
            default: if (out_ready) m_ph = 0;
         endcase
      end
      #1;
      chk("cyc_in_ready", in_ready, m_ph == 0);
      chk("cyc_busy", busy, m_ph == 1);
      chk("cyc_out_valid", out_valid, m_ph == 2);
      if (m_known) chk("cyc_out_data", out_data, m_data);
   end

   task automatic wait_valid(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); n++; #2;
         if (out_valid) break;
      end
   endtask

   task automatic start_wait(input logic [N*W-1:0] d, output int n);
      @(negedge clk);
      chk("pre_in_ready", in_ready, 1'b1);
      in_valid = 1'b1; in_data = d;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(n);
   endtask

   task automatic handshake();
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #2;
      chk("hs_out_valid", out_valid, 1'b0);
      chk("hs_in_ready", in_ready, 1'b1);
      @(negedge clk); out_ready = 1'b0;
   endtask

   task automatic run_job(input string nm, input logic [N*W-1:0] d,
                          input logic [N*W-1:0] exp, input int lat);
      int n;
      start_wait(d, n);
      chk({nm, "_lat"}, n, lat);
      chk({nm, "_data"}, out_data, exp);
      handshake();
   endtask

   initial begin
      int n;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_data", out_data, '0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      run_job("pi",   pk(3, 1, 4, 1, 5), pk(5, 4, 3, 1, 1), 10);
      run_job("desc", pk(9, 7, 5, 3, 1), pk(9, 7, 5, 3, 1), LAT_SORTED);
      run_job("ones", pk('hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF),
                      pk('hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF), LAT_SORTED);
      run_job("asc",  pk(1, 2, 3, 4, 5), pk(5, 4, 3, 2, 1), 10);
      run_job("dup",  pk(4, 0, 4, 'hFFFF, 0), pk('hFFFF, 4, 4, 0, 0), 10);

      // Backpressure with a competing job offered the whole time.
      start_wait(pk(10, 20, 30, 40, 50), n);
      chk("bp_lat", n, 10);
      @(negedge clk);
      in_valid = 1'b1; in_data = pk(7, 7, 7, 7, 7);
      repeat (20) begin
         @(posedge clk); #2;
         chk("bp_hold_data", out_data, pk(50, 40, 30, 20, 10));
         chk("bp_hold_in_ready", in_ready, 1'b0);
         chk("bp_hold_out_valid", out_valid, 1'b1);
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk); #2;
      chk("bp_rel_out_valid", out_valid, 1'b0);
      chk("bp_rel_busy", busy, 1'b0);
      chk("bp_rel_in_ready", in_ready, 1'b1);
      chk("bp_rel_data", out_data, pk(50, 40, 30, 20, 10));
      @(negedge clk) out_ready = 1'b0;
      // in_valid still high: accepted on this first IDLE edge.
      @(posedge clk); #2;
      chk("b2b_busy", busy, 1'b1);
      @(negedge clk) in_valid = 1'b0;
      wait_valid(n);
      chk("b2b_lat", n, LAT_SORTED);
      chk("b2b_data", out_data, pk(7, 7, 7, 7, 7));
      handshake();

      // Reset five edges into a job.
      @(negedge clk);
      in_valid = 1'b1; in_data = pk(3, 1, 4, 1, 5);
      @(posedge clk);
      @(negedge clk) in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_out_data", out_data, '0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #2;
         chk("post_rst_no_valid", out_valid, 1'b0);
      end
      run_job("after_rst", pk(2, 8, 6, 4, 0), pk(8, 6, 4, 2, 0), LAT_SORTED == 4 ? 7 : 10);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
